axo_wb_scheduler: RTL and testbench
===================================

// Module: axo_wb_scheduler
//
// PURPOSE
// Write-back scheduler for the single-write-port register file.
// - Arbitrates the one regfile write port between two producers: ALU/CSR (port A) and load/store unit (port L).
// - Keeps a per-register pending scoreboard and an outstanding-write counter.
// - Stalls issue on RAW, WAW or capacity hazards. Sits between the decode/issue stage and the regfile.
//
// PARAMETERS
// XLEN             32  register width in bits.
// MAX_OUTSTANDING  4   max issued-but-unwritten rd-producing instructions (>=1).
//
// PORTS
// clk          in   1     clock; all state updates on rising edge.
// rst          in   1     reset, asynchronous, active-high.
// iss_valid    in   1     issue stage presents an instruction this cycle.
// iss_has_rd   in   1     instruction writes rd (from register decoder).
// iss_rd       in   5     destination index.
// iss_rs1      in   5     source 1 index (0 = unused).
// iss_rs2      in   5     source 2 index (0 = unused).
// iss_stall    out  1     1 = issue must hold; instruction not accepted.
// a_valid      in   1     ALU write-back request.
// a_rd         in   5     ALU destination.
// a_data       in   XLEN  ALU result.
// a_ready      out  1     ALU request granted this cycle.
// l_valid      in   1     LSU write-back request.
// l_rd         in   5     LSU destination.
// l_data       in   XLEN  LSU result.
// l_ready      out  1     LSU request granted this cycle.
// rf_we        out  1     regfile write enable.
// rf_rd        out  5     regfile write index.
// rf_din       out  XLEN  regfile write data.
//
// BEHAVIOUR
// - State: pending[31:1], count (width $clog2(MAX_OUTSTANDING+1)), last_l (1 = L granted last).
// - Reset: pending=0, count=0, last_l=1. While rst=1: a_ready=l_ready=rf_we=0, iss_stall=1.
// - Arbitration, combinational, same cycle:
//   - One valid -> that port granted.
//   - Both valid -> grant goes to the port not granted last (after reset, A wins first).
//   - last_l updates on every grant: 1 if L granted, 0 if A granted.
// - Handshake: valid/ready. Transfer happens when valid && ready.
//   - Producer holds valid, rd and data stable until ready.
//   - ready never depends on iss_*. Write-back is never blocked by issue stalls.
// - Write port: rf_we = a transfer or l transfer, and rd of the granted port != 0.
//   - rf_rd and rf_din mux from the granted port. No grant -> rf_we=0, rf_rd=0, rf_din=0.
//   - A granted request with rd=0 completes (ready=1) but does not write, clear pending or decrement count.
// - Issue accepted = iss_valid && !iss_stall. Counts as a producer iff iss_has_rd && iss_rd != 0.
// - iss_stall (combinational) = iss_valid && any of the following:
//   - iss_rs1 != 0 && pending[iss_rs1]
//   - iss_rs2 != 0 && pending[iss_rs2]
//   - iss_has_rd && iss_rd != 0 && pending[iss_rd]   (WAW)
//   - iss_has_rd && iss_rd != 0 && count == MAX_OUTSTANDING
//   - The stall is conservative: a write completing in the same cycle does not release it. Release comes one cycle later.
//   - iss_stall = 0 when iss_valid = 0.
// - Scoreboard at the clock edge:
//   - A write to r clears pending[r].
//   - An accepted producer issue sets pending[iss_rd].
//   - Set and clear of the same r in one cycle: set wins. This is unreachable given the WAW stall, but required.
// - Counter: +1 on accepted producer issue, -1 on rf_we; both in one cycle -> unchanged.
//   - Must never wrap. Overflow is prevented by the stall.
//   - A write with count=0 is a protocol error: flag with an assertion, saturate at 0.
// - Reset mid-operation: all state cleared immediately (async). In-flight producers must be flushed by their own reset.
//
// TESTING
// 1. Reset, then a_valid=1 rd=5 data=0x11 -> same cycle a_ready=1, rf_we=1, rf_rd=5, rf_din=0x11; l_ready=0.
// 2. a_valid and l_valid held 4 cycles (rd 3 and 4) -> grants A,L,A,L; each port's ready high exactly on alternate cycles.
// 3. Issue rd=7; next cycle issue rs1=7 -> iss_stall=1 until the cycle after the write to x7, then 0.
// 4. Issue 4 producers (rd 1..4) with no write-backs -> 5th producer stalls, count=4.
//    - One write-back -> count=3; the following cycle the 5th issues.
// 5. a_valid rd=0 -> a_ready=1, rf_we=0, count unchanged. Issue with rd=0 -> never stalls on WAW or capacity.
// 6. Assert rst mid-burst with pending={x2,x9}, count=2 -> pending=0, count=0, outputs idle immediately.
//    - After release, rs1=2 does not stall.

Source files
------------

// File: rtl/axo_wb_scheduler.sv
// Write-back scheduler for the single-write-port register file.
// Arbitrates the regfile write port between the ALU/CSR producer (A) and the
// load/store unit (L), tracks per-register pending writes and the number of
// outstanding rd-producing instructions, and stalls issue on RAW, WAW and
// capacity hazards.

// Protocol checker: a register write with nothing outstanding is an error.
module axo_wb_scheduler_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          rf_we_i,
    input logic [CW-1:0] count_i
);

    // Flag a write-back that arrives while the outstanding counter is empty.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(rf_we_i && (count_i == '0)))
                else $error("axo_wb_scheduler: write-back with zero outstanding producers");
        end
    end

endmodule

module axo_wb_scheduler #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid_i,
    input  logic            iss_has_rd_i,
    input  logic [4:0]      iss_rd_i,
    input  logic [4:0]      iss_rs1_i,
    input  logic [4:0]      iss_rs2_i,
    output logic            iss_stall_o,
    input  logic            a_valid_i,
    input  logic [4:0]      a_rd_i,
    input  logic [XLEN-1:0] a_data_i,
    output logic            a_ready_o,
    input  logic            l_valid_i,
    input  logic [4:0]      l_rd_i,
    input  logic [XLEN-1:0] l_data_i,
    output logic            l_ready_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_din_o
);

    localparam int              CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   MAX_C = CW'(MAX_OUTSTANDING);

    // Bit 0 is never set or cleared (x0 is never a producer), which lets the
    // source/destination indices address the vector directly.
    logic [31:0]     pending_q, pending_d;
    logic [CW-1:0]   count_q, count_d;
    logic            last_l_q, last_l_d;

    logic            grant_a_s, grant_l_s;
    logic [4:0]      wb_rd_s;
    logic [XLEN-1:0] wb_data_s;
    logic            we_s;
    logic            dest_s;
    logic            hazard_s;
    logic            stall_s;
    logic            accept_prod_s;
    logic [31:0]     clr_mask_s, set_mask_s;

    // Round-robin arbitration: on contention the port not granted last wins.
    always_comb begin
        grant_a_s = 1'b0;
        grant_l_s = 1'b0;
        if (rst) begin
            grant_a_s = 1'b0;
            grant_l_s = 1'b0;
        end else if (a_valid_i && l_valid_i) begin
            grant_a_s = last_l_q;
            grant_l_s = ~last_l_q;
        end else begin
            grant_a_s = a_valid_i;
            grant_l_s = l_valid_i;
        end
    end

    // Write-port mux; a granted request to x0 completes without writing.
    always_comb begin
        wb_rd_s   = 5'd0;
        wb_data_s = '0;
        if (grant_a_s) begin
            wb_rd_s   = a_rd_i;
            wb_data_s = a_data_i;
        end else if (grant_l_s) begin
            wb_rd_s   = l_rd_i;
            wb_data_s = l_data_i;
        end else begin
            wb_rd_s   = 5'd0;
            wb_data_s = '0;
        end
        we_s = (grant_a_s || grant_l_s) && (wb_rd_s != 5'd0);
    end

    // Issue hazard detection; a write landing this cycle only releases the
    // stall on the following cycle because pending_q is the registered view.
    always_comb begin
        dest_s   = iss_has_rd_i && (iss_rd_i != 5'd0);
        hazard_s = ((iss_rs1_i != 5'd0) && pending_q[iss_rs1_i])
                || ((iss_rs2_i != 5'd0) && pending_q[iss_rs2_i])
                || (dest_s && pending_q[iss_rd_i])
                || (dest_s && (count_q == MAX_C));
        if (rst) begin
            stall_s = 1'b1;
        end else if (iss_valid_i) begin
            stall_s = hazard_s;
        end else begin
            stall_s = 1'b0;
        end
        accept_prod_s = iss_valid_i && !stall_s && dest_s;
    end

    // Next-state for scoreboard, counter and arbitration history.
    always_comb begin
        clr_mask_s = we_s          ? (32'd1 << wb_rd_s)  : 32'd0;
        set_mask_s = accept_prod_s ? (32'd1 << iss_rd_i) : 32'd0;
        // Set after clear so a same-register set wins.
        pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;

        case ({accept_prod_s, we_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = (count_q == '0) ? '0 : (count_q - CW'(1));
            default: count_d = count_q;
        endcase

        if (grant_l_s) begin
            last_l_d = 1'b1;
        end else if (grant_a_s) begin
            last_l_d = 1'b0;
        end else begin
            last_l_d = last_l_q;
        end
    end

    // State registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 32'd0;
            count_q   <= '0;
            last_l_q  <= 1'b1;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            last_l_q  <= last_l_d;
        end
    end

    assign iss_stall_o = stall_s;
    assign a_ready_o   = grant_a_s;
    assign l_ready_o   = grant_l_s;
    assign rf_we_o     = we_s;
    assign rf_rd_o     = wb_rd_s;
    assign rf_din_o    = wb_data_s;

    axo_wb_scheduler_chk #(
        .CW (CW)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .rf_we_i (we_s),
        .count_i (count_q)
    );

endmodule

// File: tb/tb_axo_wb_scheduler.sv
// Directed, table-driven bench for axo_wb_scheduler. Each record is one
// clock cycle: inputs are driven on the falling edge, combinational outputs
// are compared 1 ns later, and state advances on the following rising edge.
module tb_axo_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        iss_valid, iss_has_rd;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        iss_stall;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        l_valid;
    logic [4:0]  l_rd;
    logic [31:0] l_data;
    logic        l_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_din;

    int n_vec;
    int n_cmp;
    int n_err;

    typedef struct {
        logic        iv, hr;
        logic [4:0]  rd, rs1, rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        es, ea, el, ew;
        logic [4:0]  err;
        logic [31:0] ed;
    } vec_t;

    axo_wb_scheduler #(
        .XLEN            (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid_i  (iss_valid),
        .iss_has_rd_i (iss_has_rd),
        .iss_rd_i     (iss_rd),
        .iss_rs1_i    (iss_rs1),
        .iss_rs2_i    (iss_rs2),
        .iss_stall_o  (iss_stall),
        .a_valid_i    (a_valid),
        .a_rd_i       (a_rd),
        .a_data_i     (a_data),
        .a_ready_o    (a_ready),
        .l_valid_i    (l_valid),
        .l_rd_i       (l_rd),
        .l_data_i     (l_data),
        .l_ready_o    (l_ready),
        .rf_we_o      (rf_we),
        .rf_rd_o      (rf_rd),
        .rf_din_o     (rf_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic iv, input logic hr, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic es, input logic ea, input logic el, input logic ew,
        input logic [4:0] err, input logic [31:0] ed);
        vec_t v;
        v.iv = iv;   v.hr = hr;   v.rd = rd;   v.rs1 = rs1; v.rs2 = rs2;
        v.av = av;   v.ard = ard; v.ad = ad;
        v.lv = lv;   v.lrd = lrd; v.ld = ld;
        v.es = es;   v.ea = ea;   v.el = el;   v.ew = ew;
        v.err = err; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, compare outputs, advance to next falling edge.
    task automatic apply(input int idx, input vec_t v);
        iss_valid = v.iv; iss_has_rd = v.hr; iss_rd = v.rd;
        iss_rs1 = v.rs1;  iss_rs2 = v.rs2;
        a_valid = v.av;   a_rd = v.ard;      a_data = v.ad;
        l_valid = v.lv;   l_rd = v.lrd;      l_data = v.ld;
        #1;
        n_vec++;
        chk("iss_stall", idx, {31'd0, iss_stall}, {31'd0, v.es});
        chk("a_ready",   idx, {31'd0, a_ready},   {31'd0, v.ea});
        chk("l_ready",   idx, {31'd0, l_ready},   {31'd0, v.el});
        chk("rf_we",     idx, {31'd0, rf_we},     {31'd0, v.ew});
        chk("rf_rd",     idx, {27'd0, rf_rd},     {27'd0, v.err});
        chk("rf_din",    idx, rf_din,             v.ed);
        @(negedge clk);
    endtask

    vec_t tbl[23];
    vec_t post[7];

    initial begin
        n_vec = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1;
        iss_valid = 1'b0; iss_has_rd = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
        l_valid = 1'b0; l_rd = 5'd0; l_data = 32'd0;

        //               iv    hr    rd     rs1    rs2    av    ard    ad          lv    lrd    ld          es    ea    el    ew    err    ed
        // Basic grant: producer x5 issued, then ALU writes it back.
        tbl[0]  = mk(1'b1, 1'b1, 5'd5,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd5,  32'h11,     1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h11);
        // RAW on x7: stall holds through the write cycle, releases after.
        tbl[2]  = mk(1'b1, 1'b1, 5'd7,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[3]  = mk(1'b1, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 5'd0,  32'h0,      1'b1, 5'd7,  32'h77,     1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  32'h77);
        tbl[5]  = mk(1'b1, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        // Write-back to x0 completes without writing; issue to x0 never stalls.
        tbl[6]  = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[7]  = mk(1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        // Capacity: four producers fill the counter, fifth stalls.
        tbl[8]  = mk(1'b1, 1'b1, 5'd1,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[9]  = mk(1'b1, 1'b1, 5'd2,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[10] = mk(1'b1, 1'b1, 5'd3,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[11] = mk(1'b1, 1'b1, 5'd4,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[12] = mk(1'b1, 1'b1, 5'd6,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[13] = mk(1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[14] = mk(1'b1, 1'b1, 5'd6,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b1, 5'd1,  32'h01,     1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  32'h01);
        tbl[15] = mk(1'b1, 1'b1, 5'd6,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        // Contention held four cycles after an L grant: A, L, A, L.
        tbl[16] = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3,  32'hA3,     1'b1, 5'd4,  32'hB4,     1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'hA3);
        tbl[17] = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3,  32'hA3,     1'b1, 5'd4,  32'hB4,     1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  32'hB4);
        tbl[18] = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3,  32'hA3,     1'b1, 5'd4,  32'hB4,     1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'hA3);
        tbl[19] = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3,  32'hA3,     1'b1, 5'd4,  32'hB4,     1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  32'hB4);
        // x2 still pending: WAW and rs2 RAW stall; no stall without iss_valid.
        tbl[20] = mk(1'b1, 1'b1, 5'd2,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[21] = mk(1'b1, 1'b0, 5'd0,  5'd0,  5'd2,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        tbl[22] = mk(1'b0, 1'b0, 5'd0,  5'd2,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);

        // After a mid-burst reset: nothing pending, counter empty.
        post[0] = mk(1'b1, 1'b0, 5'd0,  5'd2,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        post[1] = mk(1'b1, 1'b1, 5'd9,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        post[2] = mk(1'b1, 1'b1, 5'd10, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        post[3] = mk(1'b1, 1'b1, 5'd11, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        post[4] = mk(1'b1, 1'b1, 5'd12, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        post[5] = mk(1'b1, 1'b1, 5'd13, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        post[6] = mk(1'b1, 1'b1, 5'd9,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0);

        // Reset state: requests present but everything idle, issue stalled.
        @(negedge clk);
        apply(100, mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22,
                      1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            apply(i, tbl[i]);
        end

        // Mid-burst reset: build pending x9/x10, start a write-back, then reset.
        apply(200, mk(1'b1, 1'b1, 5'd9,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        apply(201, mk(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        apply(202, mk(1'b0, 1'b0, 5'd0,  5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0,
                      1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99));
        rst = 1'b1;
        apply(203, mk(1'b1, 1'b0, 5'd0,  5'd10, 5'd0, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd2, 32'hBB,
                      1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            apply(300 + i, post[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
